// File: rtl/spi_mstr_core.sv
// rtl/spi_mstr_core.sv - SPI mode-0 master core with IDLE/LEAD/SHIFT/TRAIL framing
// Define SPI_MSTR_LSB_FIRST_EN to shift LSB first; MSB first otherwise.
module spi_mstr_core #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              bclk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_rx_valid;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx_data;

  logic              w_div_done;
  logic              w_accept;
  logic              w_rise;
  logic              w_fall;
  logic              w_last_fall;
  logic              w_frame_done;
  logic              w_first_bit;
  logic              w_next_bit;
  logic [DATA_W-1:0] w_tx_shifted;
  logic [DATA_W-1:0] w_rx_shifted;

`ifdef SPI_MSTR_LSB_FIRST_EN
  assign w_first_bit  = tx_data[0];
  assign w_next_bit   = r_tx_sh[1];
  assign w_tx_shifted = r_tx_sh >> 1;
  assign w_rx_shifted = {miso, r_rx_sh[DATA_W-1:1]};
`else
  assign w_first_bit  = tx_data[DATA_W-1];
  assign w_next_bit   = r_tx_sh[DATA_W-2];
  assign w_tx_shifted = r_tx_sh << 1;
  assign w_rx_shifted = {r_rx_sh[DATA_W-2:0], miso};
`endif

  assign w_div_done = (r_div == DIV_LAST);

  // SHIFT starts on a low half-period, so the final falling edge lands on TRAIL entry.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_last_fall  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_valid) begin
          w_accept = 1'b1;
          w_next   = LEAD;
        end
      end
      LEAD: begin
        if (w_div_done) w_next = SHIFT;
      end
      SHIFT: begin
        if (w_div_done) begin
          w_rise      = ~r_sclk;
          w_fall      = r_sclk;
          w_last_fall = r_sclk && (r_bit == BIT_LAST);
          if (w_last_fall) w_next = TRAIL;
        end
      end
      TRAIL: begin
        if (w_div_done) begin
          w_frame_done = 1'b1;
          w_next       = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge bclk) begin
    if (!rstn) begin
      r_div      <= '0;
      r_bit      <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= w_frame_done;
      if ((r_state == IDLE) || w_div_done) r_div <= '0;
      else                                 r_div <= r_div + 1'b1;
      if (w_accept) begin
        r_tx_sh <= tx_data;
        r_mosi  <= w_first_bit;
        r_bit   <= '0;
      end
      if (w_rise) begin
        r_sclk  <= 1'b1;
        r_rx_sh <= w_rx_shifted;
        r_bit   <= r_bit + 1'b1;
      end
      if (w_fall) begin
        r_sclk <= 1'b0;
        if (!w_last_fall) begin
          r_tx_sh <= w_tx_shifted;
          r_mosi  <= w_next_bit;
        end
      end
      if (w_frame_done) begin
        r_rx_data <= r_rx_sh;
        r_mosi    <= 1'b0;
      end
    end
  end

  assign tx_ready = (r_state == IDLE);
  assign busy     = ~tx_ready;
  assign ss_n     = (r_state == IDLE);
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_mstr_core.sv
// tb/tb_spi_mstr_core.sv - directed bench for spi_mstr_core (8-bit/div2 and 16-bit/div1 instances)
module tb_spi_mstr_core;

  logic       bclk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       use_slave = 1'b0;

  logic [15:0] tx_data1 = 16'h0000;
  logic        tx_valid1 = 1'b0;
  logic        tx_ready1;
  logic [15:0] rx_data1;
  logic        rx_valid1;
  logic        busy1;
  logic        sclk1;
  logic        ss_n1;
  logic        mosi1;

  int checks = 0;
  int errors = 0;

  always #5 bclk = ~bclk;

  spi_mstr_core #(.DATA_W(8), .CLK_DIV(2)) u_dut (
    .bclk(bclk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso)
  );

  spi_mstr_core #(.DATA_W(16), .CLK_DIV(1)) u_dut16 (
    .bclk(bclk), .rstn(rstn), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
    .sclk(sclk1), .ss_n(ss_n1), .mosi(mosi1), .miso(mosi1)
  );

  // Slave returning 0x3C: first bit on ss_n fall, next bit after each sclk fall.
  logic [7:0] slv_word = 8'h3C;
  int         slv_cnt = 0;
  int         slv_idx;
  logic       slv_bit;

  always @(negedge sclk or posedge ss_n) begin
    if (ss_n) slv_cnt <= 0;
    else      slv_cnt <= slv_cnt + 1;
  end

  always_comb begin
    slv_bit = 1'b0;
`ifdef SPI_MSTR_LSB_FIRST_EN
    slv_idx = slv_cnt;
`else
    slv_idx = 7 - slv_cnt;
`endif
    if (!ss_n && slv_cnt < 8) slv_bit = slv_word[slv_idx];
  end

  assign miso = use_slave ? slv_bit : mosi;

  task automatic do_frame(input logic [7:0] d, output int lat, output logic [7:0] bits,
                          output int rises);
    logic prev_sclk;
    @(negedge bclk);
    tx_data  = d;
    tx_valid = 1'b1;
    lat      = -1;
    rises    = 0;
    bits     = 8'h00;
    prev_sclk = sclk;
    for (int n = 1; n <= 100; n++) begin
      @(negedge bclk);
      tx_valid = 1'b0;
      if (sclk && !prev_sclk && !ss_n) begin
        rises++;
        bits = {bits[6:0], mosi};
      end
      prev_sclk = sclk;
      if (rx_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge bclk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n: got %b want 1", ss_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if ({tx_ready1, ss_n1, sclk1, rx_valid1} !== 4'b1100) begin errors++; $display("FAIL reset_dut16: got %b want 1100", {tx_ready1, ss_n1, sclk1, rx_valid1}); end
    rstn = 1'b1;
    @(negedge bclk);
  endtask

  task automatic test_loopback_a5();
    int lat; logic [7:0] bits; int rises;
    do_frame(8'hA5, lat, bits, rises);
    checks++; if (lat !== 37) begin errors++; $display("FAIL a5_latency: got %0d want 37", lat); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_rx_data: got %h want a5", rx_data); end
    checks++; if (bits !== 8'hA5) begin errors++; $display("FAIL a5_mosi_bits: got %b want 10100101", bits); end
    checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL a5_ss_n_at_rx_valid: got %b want 1", ss_n); end
    @(negedge bclk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL a5_rx_valid_strobe: got %b want 0", rx_valid); end
  endtask

  task automatic test_slave();
    int lat; logic [7:0] bits; int rises;
    use_slave = 1'b1;
    do_frame(8'hFF, lat, bits, rises);
    use_slave = 1'b0;
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL slave_rx_data: got %h want 3c", rx_data); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL slave_sclk_rises: got %0d want 8", rises); end
    checks++; if (bits !== 8'hFF) begin errors++; $display("FAIL slave_mosi_bits: got %h want ff", bits); end
  endtask

  task automatic test_ignore_busy();
    int lat;
    lat = -1;
    @(negedge bclk);
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge bclk);
      if (n == 1) begin
        tx_data = 8'hF0;
        checks++; if ({tx_ready, busy} !== 2'b01) begin errors++; $display("FAIL busy_in_lead: got %b want 01", {tx_ready, busy}); end
      end
      if (n == 30) tx_valid = 1'b0;
      if (rx_valid) begin
        lat = n;
        break;
      end
    end
    tx_valid = 1'b0;
    checks++; if (lat !== 37) begin errors++; $display("FAIL ignore_latency: got %0d want 37", lat); end
    checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL ignore_rx_data: got %h want 0f", rx_data); end
    repeat (2) @(negedge bclk);
    checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL ignore_no_restart: got ss_n %b want 1", ss_n); end
  endtask

  task automatic test_back_to_back();
    int rv_cnt; int t1; int t2; int ss_hi;
    logic [7:0] got1; logic [7:0] got2;
    rv_cnt = 0; t1 = -1; t2 = -1; ss_hi = 0; got1 = 8'h00; got2 = 8'h00;
    @(negedge bclk);
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge bclk);
      if (n == 1) tx_data = 8'h22;
      if (rv_cnt == 1 && n == t1 + 1) tx_valid = 1'b0;
      if (rv_cnt == 1 && n == t1 + 5) begin
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_rx_hold: got %h want 11", rx_data); end
      end
      if (rx_valid) begin
        rv_cnt++;
        if (rv_cnt == 1) begin
          got1 = rx_data;
          t1   = n;
        end else begin
          got2 = rx_data;
          t2   = n;
          break;
        end
      end
      if (rv_cnt == 1 && ss_n) ss_hi++;
    end
    tx_valid = 1'b0;
    checks++; if (rv_cnt !== 2) begin errors++; $display("FAIL b2b_rx_valid_count: got %0d want 2", rv_cnt); end
    checks++; if (got1 !== 8'h11) begin errors++; $display("FAIL b2b_first_word: got %h want 11", got1); end
    checks++; if (got2 !== 8'h22) begin errors++; $display("FAIL b2b_second_word: got %h want 22", got2); end
    checks++; if (ss_hi !== 1) begin errors++; $display("FAIL b2b_ss_n_gap: got %0d want 1", ss_hi); end
    checks++; if (t2 - t1 !== 37) begin errors++; $display("FAIL b2b_period: got %0d want 37", t2 - t1); end
  endtask

  task automatic test_reset_mid_frame();
    int rises; int rv_cnt; int lat; logic [7:0] bits; int r2;
    logic prev_sclk;
    rises = 0; rv_cnt = 0;
    @(negedge bclk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    prev_sclk = sclk;
    for (int n = 1; n <= 100; n++) begin
      @(negedge bclk);
      tx_valid = 1'b0;
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (rises == 3) break;
    end
    checks++; if (rises !== 3) begin errors++; $display("FAIL abort_reach_bit3: got %0d rises want 3", rises); end
    rstn = 1'b0;
    @(negedge bclk);
    rstn = 1'b1;
    checks++; if ({ss_n, sclk, tx_ready, rx_valid} !== 4'b1010) begin errors++; $display("FAIL abort_idle: got %b want 1010", {ss_n, sclk, tx_ready, rx_valid}); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx_data: got %h want 00", rx_data); end
    for (int n = 0; n < 50; n++) begin
      @(negedge bclk);
      if (rx_valid) rv_cnt++;
    end
    checks++; if (rv_cnt !== 0) begin errors++; $display("FAIL abort_no_rx_valid: got %0d want 0", rv_cnt); end
    do_frame(8'h5A, lat, bits, r2);
    checks++; if (lat !== 37) begin errors++; $display("FAIL after_abort_latency: got %0d want 37", lat); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL after_abort_rx_data: got %h want 5a", rx_data); end
  endtask

  task automatic test_wide_div1();
    int lat; int rises; logic [15:0] bits; logic [15:0] exp_bits;
    logic prev_sclk;
`ifdef SPI_MSTR_LSB_FIRST_EN
    exp_bits = 16'hF77D;
`else
    exp_bits = 16'hBEEF;
`endif
    lat = -1; rises = 0; bits = 16'h0000;
    @(negedge bclk);
    tx_data1  = 16'hBEEF;
    tx_valid1 = 1'b1;
    prev_sclk = sclk1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge bclk);
      tx_valid1 = 1'b0;
      if (sclk1 && !prev_sclk && !ss_n1) begin
        rises++;
        bits = {bits[14:0], mosi1};
      end
      prev_sclk = sclk1;
      if (rx_valid1) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 35) begin errors++; $display("FAIL w16_latency: got %0d want 35", lat); end
    checks++; if (rx_data1 !== 16'hBEEF) begin errors++; $display("FAIL w16_rx_data: got %h want beef", rx_data1); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL w16_sclk_rises: got %0d want 16", rises); end
    checks++; if (bits !== exp_bits) begin errors++; $display("FAIL w16_mosi_bits: got %h want %h", bits, exp_bits); end
  endtask

  task automatic test_bit_order();
    int lat; logic [7:0] bits; int rises; logic [7:0] exp_bits;
`ifdef SPI_MSTR_LSB_FIRST_EN
    exp_bits = 8'h80;
`else
    exp_bits = 8'h01;
`endif
    do_frame(8'h01, lat, bits, rises);
    checks++; if (bits !== exp_bits) begin errors++; $display("FAIL order_mosi_bits: got %b want %b", bits, exp_bits); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL order_rx_data: got %h want 01", rx_data); end
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_slave();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_wide_div1();
    test_bit_order();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
